// File: rtl/ultra_ram_tdp_be.sv
// True dual-port UltraRAM with per-lane byte enables, selectable write mode and
// an NBPIPE-deep valid-tagged output pipeline per port.
module ultra_ram_tdp_be #(
  parameter int unsigned AWIDTH     = 12,
  parameter int unsigned DWIDTH     = 72,
  parameter int unsigned BWIDTH     = 9,
  parameter int unsigned NBPIPE     = 3,
  parameter int unsigned WRITE_MODE = 0,
  localparam int unsigned NBYTE     = DWIDTH / BWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ena,
  input  logic [NBYTE-1:0]  wea,
  input  logic [AWIDTH-1:0] addra,
  input  logic [DWIDTH-1:0] dina,
  output logic [DWIDTH-1:0] douta,
  output logic              valida,
  input  logic              mem_enb,
  input  logic [NBYTE-1:0]  web,
  input  logic [AWIDTH-1:0] addrb,
  input  logic [DWIDTH-1:0] dinb,
  output logic [DWIDTH-1:0] doutb,
  output logic              validb,
  output logic              collision
);

  if (DWIDTH % BWIDTH != 0) begin : g_bad_width
    $error("DWIDTH must be a multiple of BWIDTH");
  end
  if (NBPIPE < 1 || NBPIPE > 8) begin : g_bad_pipe
    $error("NBPIPE must be in 1..8");
  end
  if (WRITE_MODE > 2) begin : g_bad_mode
    $error("WRITE_MODE must be 0, 1 or 2");
  end

  (* ram_style = "ultra" *) logic [DWIDTH-1:0] mem [2**AWIDTH];

  logic              acc_a, acc_b, wr_a, wr_b, res_a, res_b, col;
  logic [DWIDTH-1:0] old_a, old_b, rd_a, rd_b;

  logic [NBPIPE:0]             va_q, vb_q;
  logic [NBPIPE:0][DWIDTH-1:0] da_q, db_q;
  logic                        collision_q;

  function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old,
                                              input logic [DWIDTH-1:0] din,
                                              input logic [NBYTE-1:0]  be);
    logic [DWIDTH-1:0] r;
    r = old;
    for (int k = 0; k < NBYTE; k++) begin
      if (be[k]) r[k*BWIDTH +: BWIDTH] = din[k*BWIDTH +: BWIDTH];
    end
    return r;
  endfunction

  // Reads sample the array before this edge's writes, so a reader colliding with
  // a writer always sees the pre-write word.
  always_comb begin
    acc_a = mem_ena && !rst;
    acc_b = mem_enb && !rst;
    wr_a  = acc_a && (wea != '0);
    wr_b  = acc_b && (web != '0);
    res_a = acc_a && (!wr_a || WRITE_MODE != 0);
    res_b = acc_b && (!wr_b || WRITE_MODE != 0);
    old_a = mem[addra];
    old_b = mem[addrb];
    rd_a  = (wr_a && WRITE_MODE == 2) ? merge(old_a, dina, wea) : old_a;
    rd_b  = (wr_b && WRITE_MODE == 2) ? merge(old_b, dinb, web) : old_b;
    col   = acc_a && acc_b && (addra == addrb) && (wr_a || wr_b);
  end

  // Port A is applied last so it wins lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NBYTE; k++) begin
      if (acc_b && web[k]) mem[addrb][k*BWIDTH +: BWIDTH] <= dinb[k*BWIDTH +: BWIDTH];
      if (acc_a && wea[k]) mem[addra][k*BWIDTH +: BWIDTH] <= dina[k*BWIDTH +: BWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q        <= '0;
      vb_q        <= '0;
      da_q        <= '0;
      db_q        <= '0;
      collision_q <= 1'b0;
    end else begin
      collision_q <= col;
      va_q[0]     <= res_a;
      vb_q[0]     <= res_b;
      if (res_a) da_q[0] <= rd_a;
      if (res_b) db_q[0] <= rd_b;
      for (int i = 1; i <= NBPIPE; i++) begin
        va_q[i] <= va_q[i-1];
        vb_q[i] <= vb_q[i-1];
        if (va_q[i-1]) da_q[i] <= da_q[i-1];
        if (vb_q[i-1]) db_q[i] <= db_q[i-1];
      end
    end
  end

  assign douta     = da_q[NBPIPE];
  assign valida    = va_q[NBPIPE];
  assign doutb     = db_q[NBPIPE];
  assign validb    = vb_q[NBPIPE];
  assign collision = collision_q;

endmodule

// File: tb/tb_ultra_ram_tdp_be.sv
// Directed bench: three instances (no-change, read-first, write-first) share
// the same stimulus so mode-dependent behaviour is compared side by side.
module tb_ultra_ram_tdp_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ena, mem_enb;
  logic [7:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [71:0] dina, dinb;
  logic [71:0] douta [3];
  logic [71:0] doutb [3];
  logic        valida [3];
  logic        validb [3];
  logic        collision [3];

  int nvec = 0;
  int nerr = 0;

  localparam logic [71:0] D1   = 72'h123456789ABCDEF012;
  localparam logic [71:0] ONES = 72'hFFFFFFFFFFFFFFFFFF;
  localparam logic [71:0] DA   = 72'hAAAAAAAAAAAAAAAAAA;
  localparam logic [71:0] DB   = 72'h555555555555555555;
  localparam logic [71:0] XW   = 72'h0123456789ABCDEF01;
  localparam logic [71:0] NW   = 72'hFEDCBA9876543210FE;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    ultra_ram_tdp_be #(
      .AWIDTH(4), .DWIDTH(72), .BWIDTH(9), .NBPIPE(3), .WRITE_MODE(m)
    ) u_dut (
      .clk(clk), .rst(rst),
      .mem_ena(mem_ena), .wea(wea), .addra(addra), .dina(dina),
      .douta(douta[m]), .valida(valida[m]),
      .mem_enb(mem_enb), .web(web), .addrb(addrb), .dinb(dinb),
      .doutb(doutb[m]), .validb(validb[m]),
      .collision(collision[m])
    );
  end

  function automatic logic [71:0] pat(input int i);
    return {8'(i), 64'hDEADBEEF00000000 | 64'(i)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_ena = 1'b0;
    mem_enb = 1'b0;
    wea     = '0;
    web     = '0;
  endtask

  task automatic wait_n(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    step();
    step();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_valida_m%0d", m), 72'(valida[m]), 72'd0);
      chk($sformatf("rst_validb_m%0d", m), 72'(validb[m]), 72'd0);
      chk($sformatf("rst_coll_m%0d", m), 72'(collision[m]), 72'd0);
      chk($sformatf("rst_douta_m%0d", m), douta[m], 72'd0);
    end
    rst = 1'b0;

    // Full write on A, then read on B one cycle later.
    mem_ena = 1'b1; wea = 8'hFF; addra = 4'd5; dina = D1;
    step();
    idle(); mem_enb = 1'b1; addrb = 4'd5;
    step();
    wait_n(2);
    chk("rd5_early_validb", 72'(validb[0]), 72'd0);
    step();
    chk("rd5_validb", 72'(validb[0]), 72'd1);
    chk("rd5_doutb", doutb[0], D1);
    step();
    chk("rd5_validb_drop", 72'(validb[0]), 72'd0);
    chk("rd5_doutb_hold", doutb[0], D1);

    // Partial write over an all-ones word, per mode.
    mem_ena = 1'b1; wea = 8'hFF; addra = 4'd2; dina = ONES;
    step();
    wait_n(6);
    mem_ena = 1'b1; wea = 8'h01; addra = 4'd2; dina = '0;
    step();
    wait_n(3);
    chk("wf_valida", 72'(valida[2]), 72'd1);
    chk("wf_douta", douta[2], 72'hFFFFFFFFFFFFFFFE00);
    chk("rf_douta", douta[1], ONES);
    chk("nc_valida", 72'(valida[0]), 72'd0);
    chk("nc_douta", douta[0], 72'd0);

    // Both ports write the same address.
    mem_ena = 1'b1; wea = 8'h0F; addra = 4'd7; dina = DA;
    mem_enb = 1'b1; web = 8'hFF; addrb = 4'd7; dinb = DB;
    step();
    idle();
    chk("ww_coll_m0", 72'(collision[0]), 72'd1);
    chk("ww_coll_m2", 72'(collision[2]), 72'd1);
    step();
    chk("ww_coll_drop", 72'(collision[0]), 72'd0);
    wait_n(4);
    mem_ena = 1'b1; addra = 4'd7;
    step();
    wait_n(3);
    chk("ww_merge", douta[0], 72'h555555555AAAAAAAAA);

    // A writes while B reads the same address.
    mem_ena = 1'b1; wea = 8'hFF; addra = 4'd3; dina = XW;
    step();
    wait_n(6);
    mem_ena = 1'b1; wea = 8'hFF; addra = 4'd3; dina = NW;
    mem_enb = 1'b1; web = 8'h00; addrb = 4'd3;
    step();
    idle();
    for (int m = 0; m < 3; m++)
      chk($sformatf("wr_coll_m%0d", m), 72'(collision[m]), 72'd1);
    step();
    chk("wr_coll_drop", 72'(collision[1]), 72'd0);
    wait_n(2);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("wr_validb_m%0d", m), 72'(validb[m]), 72'd1);
      chk($sformatf("wr_doutb_m%0d", m), doutb[m], XW);
    end
    chk("wr_douta_wf", douta[2], NW);
    chk("wr_douta_rf", douta[1], XW);
    chk("wr_valida_nc", 72'(valida[0]), 72'd0);

    // Fill through B, then stream reads through A.
    for (int i = 0; i < 16; i++) begin
      mem_enb = 1'b1; web = 8'hFF; addrb = 4'(i); dinb = pat(i);
      step();
    end
    wait_n(6);
    for (int j = 0; j < 20; j++) begin
      if (j < 16) begin
        mem_ena = 1'b1; addra = 4'(j);
      end else begin
        idle();
      end
      step();
      if (j >= 3 && j < 19) begin
        chk($sformatf("stream_valid_%0d", j - 3), 72'(valida[0]), 72'd1);
        chk($sformatf("stream_data_%0d", j - 3), douta[0], pat(j - 3));
      end else begin
        chk($sformatf("stream_idle_%0d", j), 72'(valida[0]), 72'd0);
      end
    end

    // Same-address reads on both ports.
    mem_ena = 1'b1; addra = 4'd4; mem_enb = 1'b1; addrb = 4'd4;
    step();
    idle();
    chk("rr_no_coll", 72'(collision[0]), 72'd0);
    wait_n(3);
    chk("rr_douta", douta[0], pat(4));
    chk("rr_doutb", doutb[0], pat(4));

    // Reset in the middle of in-flight reads.
    wait_n(4);
    mem_ena = 1'b1; addra = 4'd0;
    step();
    addra = 4'd1;
    step();
    addra = 4'd2; rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("mid_rst_douta", douta[0], 72'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("post_rst_valida_%0d", i), 72'(valida[0]), 72'd0);
      chk($sformatf("post_rst_douta_%0d", i), douta[0], 72'd0);
      step();
    end
    mem_ena = 1'b1; addra = 4'd5;
    step();
    wait_n(2);
    chk("post_rst_early", 72'(valida[0]), 72'd0);
    step();
    chk("post_rst_valida", 72'(valida[0]), 72'd1);
    chk("post_rst_douta", douta[0], pat(5));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ultra_ram_tdp_be.md
ULTRA_RAM_TDP_BE -- requirements
Module: ultra_ram_tdp_be

Interface
REQ-001 Parameters SHALL be AWIDTH, default 12, address width; DWIDTH, default 72, data width; BWIDTH, default 9, byte-lane width; NBPIPE, default 3, number of output pipeline stages (legal range 1..8); WRITE_MODE, default 0, where 0 = no-change, 1 = read-first and 2 = write-first.
REQ-002 NBYTE SHALL be the derived value DWIDTH/BWIDTH, and elaboration SHALL fail if DWIDTH is not a multiple of BWIDTH.
REQ-003 The block SHALL have one clock, clk, with all logic on its rising edge, and reset SHALL be rst, synchronous and active-high.
REQ-004 Ports SHALL be: clk input 1, clock; rst input 1, synchronous active-high reset.
REQ-005 Port A SHALL be: mem_ena input 1, access enable; wea input NBYTE, per-lane write enable; addra input AWIDTH, address; dina input DWIDTH, write data; douta output DWIDTH, read data; valida output 1, douta carries new read data this cycle.
REQ-006 Port B SHALL be: mem_enb, web, addrb, dinb, doutb and validb, identical to port A.
REQ-007 collision SHALL be an output of width 1 that pulses when a same-address conflict occurred.
REQ-008 The storage array SHALL be 2^AWIDTH words of DWIDTH bits and SHALL carry the UltraRAM inference attribute.

Function
REQ-009 An access on port A SHALL occur in cycle t when mem_ena=1 and rst=0 (port B likewise).
REQ-010 A write SHALL be an access with wea != 0; byte lane k (bits k*BWIDTH +: BWIDTH) SHALL be updated only when wea[k]=1, and other lanes SHALL retain their contents.
REQ-011 A read access SHALL produce a result: always when we=0; when we!=0, only if WRITE_MODE is 1 or 2.
REQ-012 In no-change mode, a write SHALL produce no result, and douta/doutb SHALL hold their value.
REQ-013 Read-first mode SHALL return the whole word as it was before the write.
REQ-014 Write-first mode SHALL return the word after the write: written lanes take new data, unwritten lanes keep old data.
REQ-015 Latency: an access producing a result in cycle t SHALL present data on dout with valid=1 in cycle t+1+NBPIPE, and valid SHALL be high for exactly one cycle per result.
REQ-016 The pipeline SHALL accept one access per port per cycle at full throughput, with no stalls or bubbles.
REQ-017 Each pipeline stage SHALL carry a valid bit that advances every cycle; a data stage SHALL load only when its incoming valid bit is 1.
REQ-018 dout SHALL hold the last valid result while valid=0.
REQ-019 Collision SHALL be defined as both ports accessing the same address in the same cycle with at least one port writing.
REQ-020 On a collision with both ports writing, lanes enabled on both ports SHALL take port A data, and lanes enabled on only one port SHALL take that port's data.
REQ-021 On a collision with one port writing and the other reading, the reading port SHALL return the pre-write word in every WRITE_MODE.
REQ-022 The writing port in REQ-021 SHALL follow its own WRITE_MODE rule.
REQ-023 collision SHALL be registered and SHALL be high in cycle t+1 for exactly one cycle per colliding cycle t.
REQ-024 Two reads of the same address in the same cycle SHALL NOT be a collision, and both ports SHALL return identical data.
REQ-025 Ports A and B SHALL be fully independent except as stated in REQ-019 to REQ-024.
REQ-026 Address wrap SHALL NOT exist: every address 0..2^AWIDTH-1 is legal, and out-of-range addresses SHALL be impossible by width.

Reset
REQ-027 While rst=1, no access SHALL occur: writes are suppressed and no results are generated.
REQ-028 While rst=1, all valid pipeline bits, valida, validb and collision SHALL be cleared to 0.
REQ-029 While rst=1, douta, doutb and all data pipeline registers SHALL be cleared to 0.
REQ-030 Memory contents SHALL NOT be cleared by rst; after reset, memory retains data written before reset.
REQ-031 Reset mid-operation SHALL discard in-flight results: no valid pulse may appear for accesses issued before or during the rst cycle.
REQ-032 Accesses SHALL be accepted in the first cycle after rst falls.

Verification (AWIDTH=4, DWIDTH=72, BWIDTH=9, NBPIPE=3 unless stated)
REQ-033 Write A addr 5 data 0x123456789ABCDEF012 with wea=0xFF in cycle 0, then read B addr 5 in cycle 1 -> doutb=0x123456789ABCDEF012 with validb=1 in cycle 5 only.
REQ-034 With addr 2 holding all 0x1FF lanes, write A with wea=0x01 dina=0 in WRITE_MODE=2 -> douta has lane0=0 and lanes 1-7 = 0x1FF at t+4; the same stimulus with WRITE_MODE=0 -> valida stays 0 and douta is unchanged.
REQ-035 Both ports write addr 7 in the same cycle, A wea=0x0F and B wea=0xFF -> a later read shows lanes 0-3 from A and lanes 4-7 from B, and collision=1 for exactly one cycle at t+1.
REQ-036 A writes addr 3 while B reads addr 3 in the same cycle, with addr 3 previously holding X -> doutb=X at t+4 in every mode, and collision pulses once.
REQ-037 Back-to-back reads on A of addrs 0..15 over 16 cycles -> valida high for 16 consecutive cycles starting 4 cycles after the first read, with data in order.
REQ-038 Issue 3 reads, assert rst for 1 cycle on cycle 2, then read -> no valid pulse from the pre-reset reads, outputs are 0 during and after rst, memory data is intact, and the post-reset read returns valid data at +4.
